// File: rtl/prco_decode_stage_if.sv
// Handshake and decoded-field bundle for prco_decode_stage.
// slave = decoder side, master = fetch/execute side.
interface prco_decode_stage_if #(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 5,
  parameter int SEL_W   = 3,
  parameter int IMM_W   = 8,
  parameter int SIMM_W  = 5
);
  logic                     i_valid;
  logic [INSTR_W-1:0]       i_instr;
  logic                     o_ready;
  logic                     q_valid;
  logic                     i_ready;
  logic                     i_flush;
  logic [OP_W-1:0]          q_op;
  logic [SEL_W-1:0]         q_seld;
  logic [SEL_W-1:0]         q_sela;
  logic [SEL_W-1:0]         q_selb;
  logic                     q_third_sel;
  logic [IMM_W-1:0]         q_imm;
  logic signed [SIMM_W-1:0] q_simm;
  logic                     q_reg_we;
  logic                     q_req_alu;
  logic                     q_req_ram;
  logic                     q_req_ram_we;
  logic                     i_wb_valid;
  logic [SEL_W-1:0]         i_wb_sel;
  logic                     q_illegal;
  logic [7:0]               q_illegal_cnt;
  logic [2**SEL_W-1:0]      q_busy;

  modport slave (
    input  i_valid, i_instr, i_ready, i_flush, i_wb_valid, i_wb_sel,
    output o_ready, q_valid, q_op, q_seld, q_sela, q_selb, q_third_sel,
           q_imm, q_simm, q_reg_we, q_req_alu, q_req_ram, q_req_ram_we,
           q_illegal, q_illegal_cnt, q_busy
  );

  modport master (
    output i_valid, i_instr, i_ready, i_flush, i_wb_valid, i_wb_sel,
    input  o_ready, q_valid, q_op, q_seld, q_sela, q_selb, q_third_sel,
           q_imm, q_simm, q_reg_we, q_req_alu, q_req_ram, q_req_ram_we,
           q_illegal, q_illegal_cnt, q_busy
  );
endinterface

// File: rtl/prco_decode_stage.sv
// PRCO decode stage: field/control decode into a head+skid buffer.
// Optional register scoreboard enabled by defining PRCO_DEC_SCOREBOARD_EN.
`ifndef PRCO_OP_NOP
`define PRCO_OP_NOP  0
`define PRCO_OP_MOVI 1
`define PRCO_OP_MOV  2
`define PRCO_OP_ADD  3
`define PRCO_OP_ADDI 4
`define PRCO_OP_LW   5
`define PRCO_OP_SW   6
`define PRCO_OP_CMP  7
`define PRCO_OP_JMP  8
`define PRCO_OP_OR   9
`define PRCO_OP_XOR  10
`define PRCO_OP_AND  11
`endif
`ifndef REG_SR
`define REG_SR 7
`endif

module prco_decode_stage #(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 5,
  parameter int SEL_W   = 3,
  parameter int IMM_W   = 8,
  parameter int SIMM_W  = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  prco_decode_stage_if.slave  bus
);
  localparam int NREG = 2**SEL_W;

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(`PRCO_OP_NOP);
  localparam logic [OP_W-1:0] OP_MOVI = OP_W'(`PRCO_OP_MOVI);
  localparam logic [OP_W-1:0] OP_MOV  = OP_W'(`PRCO_OP_MOV);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(`PRCO_OP_ADD);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(`PRCO_OP_ADDI);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(`PRCO_OP_LW);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(`PRCO_OP_SW);
  localparam logic [OP_W-1:0] OP_CMP  = OP_W'(`PRCO_OP_CMP);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(`PRCO_OP_JMP);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(`PRCO_OP_OR);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(`PRCO_OP_XOR);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(`PRCO_OP_AND);
  localparam logic [SEL_W-1:0] SR_SEL = SEL_W'(`REG_SR);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [SEL_W-1:0]  seld;
    logic [SEL_W-1:0]  sela;
    logic [SEL_W-1:0]  selb;
    logic              third_sel;
    logic [IMM_W-1:0]  imm;
    logic [SIMM_W-1:0] simm;
    logic              reg_we;
    logic              req_alu;
    logic              req_ram;
    logic              req_ram_we;
  } entry_t;

  entry_t     dec;
  entry_t     head_reg;
  entry_t     skid_reg;
  logic       head_valid_reg;
  logic       skid_valid_reg;
  logic       illegal_reg;
  logic [7:0] illegal_cnt_reg;
  logic       known;
  logic       is_nop;
  logic       accept;
  logic       push;
  logic       illegal_in;
  logic       hazard;
  logic       q_valid;
  logic       xfer;

  always_comb begin
    dec            = '0;
    known          = 1'b1;
    is_nop         = 1'b0;
    dec.op         = bus.i_instr[INSTR_W-1 -: OP_W];
    dec.seld       = bus.i_instr[INSTR_W-OP_W-1 -: SEL_W];
    dec.sela       = bus.i_instr[INSTR_W-OP_W-SEL_W-1 -: SEL_W];
    dec.selb       = bus.i_instr[INSTR_W-OP_W-2*SEL_W-1 -: SEL_W];
    dec.imm        = bus.i_instr[IMM_W-1:0];
    dec.simm       = bus.i_instr[SIMM_W-1:0];
    case (dec.op)
      OP_NOP:                               is_nop = 1'b1;
      OP_MOVI, OP_MOV:                      dec.reg_we = 1'b1;
      OP_ADD, OP_ADDI, OP_OR, OP_XOR, OP_AND: begin
        dec.reg_we  = 1'b1;
        dec.req_alu = 1'b1;
      end
      OP_CMP: begin
        dec.reg_we    = 1'b1;
        dec.req_alu   = 1'b1;
        dec.third_sel = 1'b1;
      end
      OP_JMP: begin
        dec.reg_we = 1'b1;
        dec.sela   = SR_SEL;
      end
      OP_LW: begin
        dec.reg_we  = 1'b1;
        dec.req_ram = 1'b1;
      end
      OP_SW: begin
        dec.req_ram    = 1'b1;
        dec.req_ram_we = 1'b1;
      end
      default:                              known = 1'b0;
    endcase
  end

  // NOPs and unknown opcodes are consumed by the handshake but never enter the buffer.
  assign accept     = bus.i_valid && !skid_valid_reg && !bus.i_flush;
  assign push       = accept && known && !is_nop;
  assign illegal_in = accept && !known;
  assign q_valid    = head_valid_reg && !hazard;
  assign xfer       = q_valid && bus.i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      head_valid_reg  <= 1'b0;
      skid_valid_reg  <= 1'b0;
      head_reg        <= '0;
      skid_reg        <= '0;
      illegal_reg     <= 1'b0;
      illegal_cnt_reg <= '0;
    end else begin
      illegal_reg <= illegal_in;
      if (illegal_in && illegal_cnt_reg != 8'hFF)
        illegal_cnt_reg <= illegal_cnt_reg + 8'd1;
      if (bus.i_flush) begin
        head_valid_reg <= 1'b0;
        skid_valid_reg <= 1'b0;
      end else if (!head_valid_reg || xfer) begin
        if (skid_valid_reg) begin
          head_reg       <= skid_reg;
          head_valid_reg <= 1'b1;
          skid_valid_reg <= push;
          if (push)
            skid_reg <= dec;
        end else begin
          head_valid_reg <= push;
          if (push)
            head_reg <= dec;
        end
      end else if (push) begin
        skid_reg       <= dec;
        skid_valid_reg <= 1'b1;
      end
    end
  end

`ifdef PRCO_DEC_SCOREBOARD_EN
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] wb_clr;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] busy_eff;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      assign wb_clr[gi]   = bus.i_wb_valid && (bus.i_wb_sel == SEL_W'(gi));
      assign set_mask[gi] = xfer && head_reg.reg_we && (head_reg.seld == SEL_W'(gi));
    end
  endgenerate

  // Retire bypasses into this cycle's hazard check so a waiting consumer issues immediately.
  assign busy_eff = busy_reg & ~wb_clr;
  assign hazard   = busy_eff[head_reg.sela]
                 || (head_reg.third_sel && busy_eff[head_reg.selb])
                 || ((head_reg.reg_we || head_reg.req_ram_we) && busy_eff[head_reg.seld]);

  always_ff @(posedge i_clk) begin
    if (!i_reset)
      busy_reg <= '0;
    else
      busy_reg <= (busy_reg & ~wb_clr) | set_mask;
  end

  assign bus.q_busy = busy_reg;
`else
  logic unused_wb;
  assign unused_wb  = ^{bus.i_wb_valid, bus.i_wb_sel};
  assign hazard     = 1'b0;
  assign bus.q_busy = '0;
`endif

  assign bus.o_ready       = !skid_valid_reg;
  assign bus.q_valid       = q_valid;
  assign bus.q_op          = head_reg.op;
  assign bus.q_seld        = head_reg.seld;
  assign bus.q_sela        = head_reg.sela;
  assign bus.q_selb        = head_reg.selb;
  assign bus.q_third_sel   = head_reg.third_sel;
  assign bus.q_imm         = head_reg.imm;
  assign bus.q_simm        = head_reg.simm;
  assign bus.q_reg_we      = head_reg.reg_we;
  assign bus.q_req_alu     = head_reg.req_alu;
  assign bus.q_req_ram     = head_reg.req_ram;
  assign bus.q_req_ram_we  = head_reg.req_ram_we;
  assign bus.q_illegal     = illegal_reg;
  assign bus.q_illegal_cnt = illegal_cnt_reg;
endmodule

// File: tb/tb_prco_decode_stage.sv
// Directed, table-driven bench for prco_decode_stage (default parameters).
// Scoreboard sequences run only when PRCO_DEC_SCOREBOARD_EN is defined.
module tb_prco_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prco_decode_stage_if bus ();
  prco_decode_stage dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));

  localparam logic [4:0] OP_NOP = 5'd0,  OP_MOVI = 5'd1, OP_MOV = 5'd2,  OP_ADD = 5'd3;
  localparam logic [4:0] OP_LW  = 5'd5,  OP_SW   = 5'd6, OP_CMP = 5'd7,  OP_JMP = 5'd8;
  localparam logic [4:0] OP_XOR = 5'd10, OP_BAD  = 5'd20;

  typedef struct {
    logic [15:0] instr;
    logic [4:0]  op;
    logic [2:0]  d, a, b;
    logic        third;
    logic [7:0]  imm;
    logic [4:0]  simm;
    logic        we, alu, ram, rw;
  } vec_t;

  vec_t vecs [8];
  int   total = 0;
  int   bad   = 0;
  int   pulses;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] d,
                                     input logic [2:0] a, input logic [2:0] b,
                                     input logic [1:0] lo);
    return {op, d, a, b, lo};
  endfunction

  function automatic logic [31:0] fields();
    return {bus.q_op, bus.q_seld, bus.q_sela, bus.q_selb, bus.q_third_sel, bus.q_imm,
            bus.q_simm, bus.q_reg_we, bus.q_req_alu, bus.q_req_ram, bus.q_req_ram_we};
  endfunction

  function automatic logic [31:0] exp_fields(input vec_t v);
    return {v.op, v.d, v.a, v.b, v.third, v.imm, v.simm, v.we, v.alu, v.ram, v.rw};
  endfunction

  task automatic idle_inputs();
    bus.i_valid    = 1'b0;
    bus.i_instr    = '0;
    bus.i_ready    = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_wb_valid = 1'b0;
    bus.i_wb_sel   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{16'h1BA6, OP_ADD,  3'd3, 3'd5, 3'd1, 1'b0, 8'hA6, 5'h06, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h3953, OP_CMP,  3'd1, 3'd2, 3'd4, 1'b1, 8'h53, 5'h13, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h40C8, OP_JMP,  3'd0, 3'd7, 3'd2, 1'b0, 8'hC8, 5'h08, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h2C21, OP_LW,   3'd4, 3'd1, 3'd0, 1'b0, 8'h21, 5'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h327F, OP_SW,   3'd2, 3'd3, 3'd7, 1'b0, 8'h7F, 5'h1F, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{16'h0FFF, OP_MOVI, 3'd7, 3'd7, 3'd7, 1'b0, 8'hFF, 5'h1F, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h550C, OP_XOR,  3'd5, 3'd0, 3'd3, 1'b0, 8'h0C, 5'h0C, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h1696, OP_MOV,  3'd6, 3'd4, 3'd5, 1'b0, 8'h96, 5'h16, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset wins over concurrent valid/wb activity
    idle_inputs();
    bus.i_valid    = 1'b1;
    bus.i_instr    = vecs[0].instr;
    bus.i_wb_valid = 1'b1;
    tick();
    tick();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    chk("rst_q_valid", 64'(bus.q_valid), 64'd0);
    chk("rst_o_ready", 64'(bus.o_ready), 64'd1);
    chk("rst_illegal", 64'(bus.q_illegal), 64'd0);
    chk("rst_ill_cnt", 64'(bus.q_illegal_cnt), 64'd0);
    chk("rst_busy", 64'(bus.q_busy), 64'd0);
    chk("rst_fields", 64'(fields()), 64'd0);

    // Field/control decode table: accept, hold under backpressure, transfer, retire
    for (int i = 0; i < 8; i++) begin
      bus.i_valid = 1'b1;
      bus.i_instr = vecs[i].instr;
      tick();
      bus.i_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(bus.q_valid), 64'd1);
      chk($sformatf("vec%0d_fields", i), 64'(fields()), 64'(exp_fields(vecs[i])));
      tick();
      chk($sformatf("vec%0d_hold", i), 64'(fields()), 64'(exp_fields(vecs[i])));
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      chk($sformatf("vec%0d_drain", i), 64'(bus.q_valid), 64'd0);
      bus.i_wb_valid = 1'b1;
      bus.i_wb_sel   = vecs[i].d;
      tick();
      bus.i_wb_valid = 1'b0;
      $display("vec %0d instr=%h op=%0d seld=%0d sela=%0d", i, vecs[i].instr,
               bus.q_op, bus.q_seld, bus.q_sela);
    end

    // Backpressure: two accepts fill the buffer, third held, then drained in order
    do_reset();
    bus.i_valid = 1'b1;
    bus.i_instr = mk(OP_ADD, 3'd1, 3'd5, 3'd0, 2'd0);
    #1 chk("strm_rdy0", 64'(bus.o_ready), 64'd1);
    tick();
    bus.i_instr = mk(OP_ADD, 3'd2, 3'd5, 3'd0, 2'd0);
    #1 chk("strm_rdy1", 64'(bus.o_ready), 64'd1);
    tick();
    bus.i_instr = mk(OP_ADD, 3'd3, 3'd6, 3'd0, 2'd0);
    #1 chk("strm_full", 64'(bus.o_ready), 64'd0);
    tick();
    chk("strm_still_full", 64'(bus.o_ready), 64'd0);
    chk("strm_head_hold", 64'(bus.q_seld), 64'd1);
    bus.i_ready = 1'b1;
    #1 chk("strm_out0", 64'({bus.q_valid, bus.q_seld}), 64'({1'b1, 3'd1}));
    tick();
    chk("strm_out1", 64'({bus.q_valid, bus.q_seld}), 64'({1'b1, 3'd2}));
    tick();
    bus.i_valid = 1'b0;
    chk("strm_out2", 64'({bus.q_valid, bus.q_seld}), 64'({1'b1, 3'd3}));
    tick();
    chk("strm_empty", 64'(bus.q_valid), 64'd0);
    $display("stream 3 instructions delivered");

    // NOP / illegal consumption and counter saturation
    do_reset();
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_instr = mk(OP_NOP, 3'd1, 3'd1, 3'd1, 2'd0);
    tick();
    chk("nop_valid", 64'({bus.q_valid, bus.q_illegal}), 64'd0);
    bus.i_instr = mk(OP_BAD, 3'd1, 3'd1, 3'd1, 2'd0);
    tick();
    chk("ill_pulse", 64'({bus.q_valid, bus.q_illegal}), 64'b01);
    chk("ill_cnt1", 64'(bus.q_illegal_cnt), 64'd1);
    bus.i_instr = mk(OP_NOP, 3'd0, 3'd0, 3'd0, 2'd0);
    tick();
    chk("ill_clear", 64'({bus.q_valid, bus.q_illegal}), 64'd0);
    chk("ill_cnt_hold", 64'(bus.q_illegal_cnt), 64'd1);
    bus.i_instr = mk(OP_BAD, 3'd2, 3'd3, 3'd4, 2'd1);
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.q_illegal) pulses++;
      if (bus.q_valid) chk("ill_no_valid", 64'(bus.q_valid), 64'd0);
    end
    bus.i_valid = 1'b0;
    tick();
    chk("ill_pulses", 64'(pulses), 64'd300);
    chk("ill_sat", 64'(bus.q_illegal_cnt), 64'd255);
    chk("ill_end", 64'({bus.q_valid, bus.q_illegal}), 64'd0);
    $display("illegal burst pulses=%0d cnt=%0d", pulses, bus.q_illegal_cnt);

    // Flush with full buffer drops everything including the same-cycle input
    do_reset();
    bus.i_valid = 1'b1;
    bus.i_instr = mk(OP_MOV, 3'd1, 3'd2, 3'd3, 2'd0);
    tick();
    bus.i_instr = mk(OP_MOV, 3'd4, 3'd2, 3'd3, 2'd0);
    tick();
    chk("fl_full", 64'(bus.o_ready), 64'd0);
    bus.i_instr = mk(OP_MOV, 3'd5, 3'd2, 3'd3, 2'd0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    chk("fl_state", 64'({bus.q_valid, bus.o_ready}), 64'b01);
    tick();
    chk("fl_dropped", 64'(bus.q_valid), 64'd0);
    chk("fl_cnt", 64'(bus.q_illegal_cnt), 64'd0);
    $display("flush cleared buffer");

    // Sustained one-per-cycle throughput with i_ready held high
    do_reset();
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_instr = mk(OP_MOV, 3'(i + 1), 3'd0, 3'd0, 2'd0);
      #1 chk($sformatf("tp_rdy%0d", i), 64'(bus.o_ready), 64'd1);
      tick();
      chk($sformatf("tp_out%0d", i), 64'({bus.q_valid, bus.q_seld}), 64'({1'b1, 3'(i + 1)}));
    end
    bus.i_valid = 1'b0;
    tick();
    chk("tp_empty", 64'(bus.q_valid), 64'd0);
    $display("throughput 4 instructions back to back");

`ifdef PRCO_DEC_SCOREBOARD_EN
    // RAW on ra: ADD waits for MOVI's destination to retire, issues in the retire cycle
    do_reset();
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_instr = mk(OP_MOVI, 3'd2, 3'd0, 3'd0, 2'd0);
    tick();
    bus.i_instr = mk(OP_ADD, 3'd1, 3'd2, 3'd0, 2'd0);
    #1 chk("sb_movi_issue", 64'(bus.q_valid), 64'd1);
    tick();
    bus.i_valid = 1'b0;
    #1 chk("sb_stall", 64'(bus.q_valid), 64'd0);
    chk("sb_busy2", 64'(bus.q_busy), 64'h04);
    tick();
    chk("sb_stall2", 64'(bus.q_valid), 64'd0);
    bus.i_wb_valid = 1'b1;
    bus.i_wb_sel   = 3'd2;
    #1 chk("sb_bypass", 64'(bus.q_valid), 64'd1);
    tick();
    bus.i_wb_valid = 1'b0;
    chk("sb_after", 64'({bus.q_valid, bus.q_busy}), 64'({1'b0, 8'h02}));
    $display("scoreboard ra hazard resolved");

    // CMP hazard on selb, then same-cycle set and clear of one register
    do_reset();
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_instr = mk(OP_MOVI, 3'd4, 3'd0, 3'd0, 2'd0);
    tick();
    bus.i_instr = mk(OP_CMP, 3'd1, 3'd0, 3'd4, 2'd0);
    tick();
    bus.i_valid = 1'b0;
    #1 chk("cmp_stall", 64'({bus.q_valid, bus.q_third_sel, bus.q_busy}), 64'({2'b01, 8'h10}));
    bus.i_wb_valid = 1'b1;
    bus.i_wb_sel   = 3'd4;
    #1 chk("cmp_issue", 64'(bus.q_valid), 64'd1);
    tick();
    bus.i_wb_valid = 1'b0;
    chk("cmp_busy", 64'(bus.q_busy), 64'h02);
    bus.i_valid = 1'b1;
    bus.i_instr = mk(OP_MOVI, 3'd4, 3'd0, 3'd0, 2'd0);
    tick();
    bus.i_valid    = 1'b0;
    bus.i_wb_valid = 1'b1;
    bus.i_wb_sel   = 3'd4;
    #1 chk("setclr_issue", 64'(bus.q_valid), 64'd1);
    tick();
    bus.i_wb_valid = 1'b0;
    chk("setclr_wins", 64'(bus.q_busy[4]), 64'd1);
    $display("scoreboard selb hazard and set-over-clear checked");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
